// File: rtl/face_result_packer.sv
// face_result_packer: buffers detection records and serializes them plus an end-of-frame summary as UART byte packets
`ifndef PYRAMID_LEVELS
`define PYRAMID_LEVELS 10
`endif
module face_result_packer #(
  parameter int FIFO_DEPTH     = 16,
  parameter int PYRAMID_LEVELS = `PYRAMID_LEVELS
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [1:0][31:0]              face_coords,
  input  logic                          face_coords_ready,
  input  logic [3:0]                    pyramid_number,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {S_IDLE, S_REC, S_END} state_t;
  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [35:0]     shadow_q, shadow_d;
  logic [35:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      face_q, face_d, drop_q, drop_d;
  logic            pend_q, pend_d;
  logic [3:0]      pyr_q;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, busy_q;
  logic            hs, pop, full, push, drop, end_done, frame_end;
  logic            unused_ok;
  assign unused_ok = ^{face_coords[0][31:16], face_coords[1][31:16]};
  assign hs        = (state_q != S_IDLE) && tx_ready;
  assign pop       = (state_q == S_IDLE) && (cnt_q != '0);
  assign full      = cnt_q == CW'(FIFO_DEPTH);
  assign push      = face_coords_ready && (!full || pop);
  assign drop      = face_coords_ready && !push;
  assign end_done  = (state_q == S_END) && hs && (idx_q == 3'd2);
  assign frame_end = (pyr_q == 4'(PYRAMID_LEVELS - 1)) && (pyramid_number == 4'hF);
  // FIFO occupancy, saturating detection/drop counters and the pending end-of-frame flag
  always_comb begin
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    face_d = end_done ? {7'd0, push} : (push && face_q != 8'hFF) ? face_q + 8'd1 : face_q;
    drop_d = end_done ? {7'd0, drop} : (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    pend_d = frame_end | (pend_q & ~end_done);
  end
  // Packet sequencer: records first, end packet only once the FIFO is empty; end counts are snapshotted so bytes stay stable
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    if (state_q == S_IDLE) begin
      if (pop) begin
        state_d  = S_REC;
        idx_d    = 3'd0;
        shadow_d = mem[rd_q];
      end else if (pend_q) begin
        state_d  = S_END;
        idx_d    = 3'd0;
        shadow_d = {20'd0, face_d, drop_d};
      end
    end else if (hs) begin
      idx_d = idx_q + 3'd1;
      if (idx_q == ((state_q == S_REC) ? 3'd5 : 3'd2)) state_d = S_IDLE;
    end
  end
  // Byte for the next cycle, derived from next state so tx_data is a plain register
  always_comb begin
    tx_data_d = 8'h00;
    if (state_d == S_REC)
      tx_data_d = (idx_d == 3'd0) ? 8'hA5 :
                  (idx_d == 3'd1) ? {4'h0, shadow_d[35:32]} :
                  (idx_d == 3'd2) ? shadow_d[31:24] :
                  (idx_d == 3'd3) ? shadow_d[23:16] :
                  (idx_d == 3'd4) ? shadow_d[15:8] : shadow_d[7:0];
    else if (state_d == S_END)
      tx_data_d = (idx_d == 3'd0) ? 8'h5A : (idx_d == 3'd1) ? shadow_d[15:8] : shadow_d[7:0];
  end
  // Record storage; contents need no reset since pointers and count gate every read
  always_ff @(posedge clock) begin
    if (push) mem[wr_q] <= {pyramid_number, face_coords[0][15:0], face_coords[1][15:0]};
  end
  // All control state and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      shadow_q   <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      face_q     <= '0;
      drop_q     <= '0;
      pend_q     <= 1'b0;
      pyr_q      <= 4'hF;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q      <= cnt_d;
      face_q     <= face_d;
      drop_q     <= drop_d;
      pend_q     <= pend_d;
      pyr_q      <= pyramid_number;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= state_d != S_IDLE;
      busy_q     <= (cnt_d != '0) || pend_d || (state_d != S_IDLE);
    end
  end
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign busy       = busy_q;
  assign fifo_count = cnt_q;
endmodule

// File: tb/tb_face_result_packer.sv
// tb_face_result_packer: scoreboard bench for the detection packet serializer
module tb_face_result_packer;
  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [1:0][31:0] face_coords = '0;
  logic             face_coords_ready = 1'b0;
  logic [3:0]       pyramid_number = 4'hF;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready = 1'b0;
  logic             busy;
  logic [4:0]       fifo_count;
  logic [7:0]       exp_q[$];
  logic [7:0]       exp_b;
  logic [7:0]       stall_data;
  logic             stall_q = 1'b0;
  int               n_vec = 0;
  int               n_err = 0;
  int               hs_cnt = 0;

  always #5 clock = ~clock;

  face_result_packer #(.FIFO_DEPTH(16), .PYRAMID_LEVELS(10)) dut (
    .clock(clock), .reset(reset), .face_coords(face_coords),
    .face_coords_ready(face_coords_ready), .pyramid_number(pyramid_number),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .fifo_count(fifo_count)
  );

  // Byte monitor: compare every handshake against the scoreboard and check stall stability
  always @(negedge clock) begin
    if (stall_q && reset === 1'b1) begin
      n_vec++;
      if (tx_valid !== 1'b1 || tx_data !== stall_data) begin
        n_err++;
        $display("FAIL hold: valid=%b data=%h, required valid=1 data=%h", tx_valid, tx_data, stall_data);
      end
    end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      hs_cnt++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_byte: got %h, required none", tx_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (tx_data !== exp_b) begin
          n_err++;
          $display("FAIL byte: got %h, required %h", tx_data, exp_b);
        end
      end
    end
    stall_q    = (tx_valid === 1'b1) && (tx_ready !== 1'b1);
    stall_data = tx_data;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_rec(input logic [3:0] lv, input logic [15:0] r, input logic [15:0] c);
    exp_q.push_back(8'hA5);
    exp_q.push_back({4'h0, lv});
    exp_q.push_back(r[15:8]);
    exp_q.push_back(r[7:0]);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[7:0]);
  endtask

  task automatic push_end(input logic [7:0] f, input logic [7:0] d);
    exp_q.push_back(8'h5A);
    exp_q.push_back(f);
    exp_q.push_back(d);
  endtask

  task automatic strobe(input logic [15:0] r, input logic [15:0] c, input logic [3:0] lv, input bit accepted);
    face_coords[0]    = {16'hBEEF, r};
    face_coords[1]    = {16'hCAFE, c};
    pyramid_number    = lv;
    face_coords_ready = 1'b1;
    if (accepted) push_rec(lv, r, c);
    tick();
    face_coords_ready = 1'b0;
  endtask

  task automatic frame_end();
    pyramid_number = 4'd9;
    tick();
    pyramid_number = 4'hF;
    tick();
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && k < budget) begin
      tick();
      k++;
    end
    n_vec++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_drain: %0d bytes outstanding busy=%b, required 0 bytes busy=0", name, exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    n_vec += 4;
    if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, required 0", tx_valid); end
    if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h, required 00", tx_data); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (fifo_count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d, required 0", fifo_count); end
  endtask

  task automatic test_single();
    int base;
    tx_ready = 1'b1;
    strobe(16'd37, 16'd112, 4'd3, 1'b1);
    n_vec += 3;
    if (fifo_count !== 5'd1) begin n_err++; $display("FAIL single_push_count: got %0d, required 1", fifo_count); end
    if (tx_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid: got %b, required 0", tx_valid); end
    if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b, required 1", busy); end
    tick();
    n_vec += 3;
    if (tx_valid !== 1'b1) begin n_err++; $display("FAIL single_first_valid: got %b, required 1", tx_valid); end
    if (tx_data !== 8'hA5) begin n_err++; $display("FAIL single_first_data: got %h, required a5", tx_data); end
    if (fifo_count !== 5'd0) begin n_err++; $display("FAIL single_pop_count: got %0d, required 0", fifo_count); end
    base = hs_cnt;
    repeat (6) tick();
    n_vec++;
    if (hs_cnt - base != 6) begin n_err++; $display("FAIL single_rate: got %0d handshakes, required 6", hs_cnt - base); end
    drain("single", 50);
  endtask

  task automatic test_backpressure();
    int base = hs_cnt;
    tx_ready = 1'b1;
    strobe(16'd37, 16'd112, 4'd3, 1'b1);
    for (int i = 0; i < 40; i++) begin
      tx_ready = (i % 3 == 0);
      tick();
    end
    tx_ready = 1'b1;
    n_vec++;
    if (hs_cnt - base != 6) begin n_err++; $display("FAIL bp_handshakes: got %0d, required 6", hs_cnt - base); end
    drain("bp", 50);
  endtask

  task automatic test_frame_count();
    push_end(8'd2, 8'd0);
    frame_end();
    drain("frame_count", 50);
  endtask

  task automatic test_overflow();
    tx_ready = 1'b0;
    for (int i = 0; i < 19; i++)
      strobe(16'(i * 7 + 1), 16'(16'h0100 + i), 4'd2, i < 17);
    n_vec++;
    if (fifo_count !== 5'd16) begin n_err++; $display("FAIL ovf_count: got %0d, required 16", fifo_count); end
    push_end(8'h11, 8'h02);
    frame_end();
    tx_ready = 1'b1;
    drain("ovf", 500);
  endtask

  task automatic test_frame_end_order();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      strobe(16'(16'h1200 + i), 16'(16'h3400 + i), 4'd9, 1'b1);
    strobe(16'hABCD, 16'h0123, 4'hF, 1'b1);
    push_end(8'h04, 8'h00);
    repeat (3) tick();
    tx_ready = 1'b1;
    drain("order", 200);
  endtask

  task automatic test_empty_frame();
    tx_ready = 1'b1;
    push_end(8'h00, 8'h00);
    frame_end();
    drain("empty", 50);
  endtask

  task automatic test_reset_mid();
    int base = hs_cnt;
    int k = 0;
    tx_ready = 1'b1;
    strobe(16'h0055, 16'h0066, 4'd5, 1'b1);
    strobe(16'h0077, 16'h0088, 4'd5, 1'b0);
    while (hs_cnt - base < 3 && k < 50) begin
      tick();
      k++;
    end
    n_vec++;
    if (hs_cnt - base < 3) begin n_err++; $display("FAIL mid_wait: got %0d handshakes, required 3", hs_cnt - base); end
    reset = 1'b0;
    #1;
    exp_q.delete();
    n_vec += 3;
    if (tx_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b, required 0", tx_valid); end
    if (fifo_count !== 5'd0) begin n_err++; $display("FAIL mid_count: got %0d, required 0", fifo_count); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b, required 0", busy); end
    repeat (2) tick();
    reset = 1'b1;
    base = hs_cnt;
    repeat (20) tick();
    n_vec += 2;
    if (hs_cnt != base) begin n_err++; $display("FAIL mid_quiet: got %0d handshakes, required 0", hs_cnt - base); end
    if (tx_valid !== 1'b0) begin n_err++; $display("FAIL mid_quiet_valid: got %b, required 0", tx_valid); end
    strobe(16'h0999, 16'h0AAA, 4'd1, 1'b1);
    drain("mid_resume", 50);
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_frame_count();
    test_overflow();
    test_frame_end_order();
    test_empty_frame();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
